// File: rtl/multibyte_adder_sequencer.sv
// multibyte_adder_sequencer
// Performs wide add/subtract/add-with-carry/subtract-with-borrow by running one
// shared 8-bit Kogge-Stone adder slice over the operand bytes, least-significant
// byte first, one byte per clock. The carry between bytes lives in a register.
// The request side is a valid/ready handshake. Results are presented on a
// valid/ready response handshake and are held until the consumer accepts them.

module multibyte_adder_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 request_valid,
  output logic                 request_ready,
  input  logic [1:0]           operation,
  input  logic [8*WORDS-1:0]   source_element_0,
  input  logic [8*WORDS-1:0]   source_element_1,
  input  logic                 input_carry,
  output logic                 response_valid,
  input  logic                 response_ready,
  output logic [8*WORDS-1:0]   result,
  output logic                 output_carry,
  output logic                 overflow,
  output logic                 zero
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;

  logic [1:0]         state;
  logic [IDX_W-1:0]   index;
  logic [8*WORDS-1:0] operand_a;
  logic [8*WORDS-1:0] operand_b;
  logic               subtract;
  logic               carry_reg;
  logic               initial_carry;

  logic [7:0] byte_a;
  logic [7:0] byte_b;
  logic [7:0] g0, p0, g1, p1, g2, p2, g3, p3;
  logic [7:0] bitwise_carry;
  logic [7:0] slice_sum;
  logic       slice_carry;
  logic [8*WORDS-1:0] merged_result;

  assign request_ready  = (state == ST_IDLE);
  assign response_valid = (state == ST_DONE);

  // Carry entering the least-significant byte; SUB/SBB rely on B being inverted later.
  always_comb begin
    initial_carry = input_carry;
    if (operation == OP_ADD) initial_carry = 1'b0;
    else if (operation == OP_SUB) initial_carry = 1'b1;
  end

  // Select the current byte of each captured operand; B is inverted for subtraction.
  always_comb begin
    byte_a = 8'h00;
    byte_b = 8'h00;
    for (int i = 0; i < WORDS; i++) begin
      if (index == IDX_W'(i)) begin
        byte_a = operand_a[i*8 +: 8];
        byte_b = operand_b[i*8 +: 8];
      end
    end
    byte_b = byte_b ^ {8{subtract}};
  end

  // Kogge-Stone prefix network: group generate/propagate over bits [i:0] in three levels.
  always_comb begin
    g0 = byte_a & byte_b;
    p0 = byte_a ^ byte_b;
    g1 = g0;
    p1 = p0;
    for (int i = 1; i < 8; i++) begin
      g1[i] = g0[i] | (p0[i] & g0[i-1]);
      p1[i] = p0[i] & p0[i-1];
    end
    g2 = g1;
    p2 = p1;
    for (int i = 2; i < 8; i++) begin
      g2[i] = g1[i] | (p1[i] & g1[i-2]);
      p2[i] = p1[i] & p1[i-2];
    end
    g3 = g2;
    p3 = p2;
    for (int i = 4; i < 8; i++) begin
      g3[i] = g2[i] | (p2[i] & g2[i-4]);
      p3[i] = p2[i] & p2[i-4];
    end
  end

  // Fold the registered carry-in into the prefix terms to get per-bit carries and the sum.
  always_comb begin
    bitwise_carry    = 8'h00;
    bitwise_carry[0] = carry_reg;
    for (int j = 1; j < 8; j++) begin
      bitwise_carry[j] = g3[j-1] | (p3[j-1] & carry_reg);
    end
    slice_carry = g3[7] | (p3[7] & carry_reg);
    slice_sum   = p0 ^ bitwise_carry;
  end

  // Result with the current byte replaced by this cycle's sum, used for writeback and zero.
  always_comb begin
    merged_result = result;
    for (int i = 0; i < WORDS; i++) begin
      if (index == IDX_W'(i)) merged_result[i*8 +: 8] = slice_sum;
    end
  end

  // Sequencer: capture request, walk the bytes through the slice, then hold the response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      index        <= '0;
      operand_a    <= '0;
      operand_b    <= '0;
      subtract     <= 1'b0;
      carry_reg    <= 1'b0;
      result       <= '0;
      output_carry <= 1'b0;
      overflow     <= 1'b0;
      zero         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (request_valid) begin
            operand_a <= source_element_0;
            operand_b <= source_element_1;
            subtract  <= operation[0];
            carry_reg <= initial_carry;
            result    <= '0;
            index     <= '0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          result    <= merged_result;
          carry_reg <= slice_carry;
          if (index == LAST_IDX) begin
            output_carry <= slice_carry;
            overflow     <= bitwise_carry[7] ^ slice_carry;
            zero         <= (merged_result == '0);
            index        <= '0;
            state        <= ST_DONE;
          end else begin
            index <= index + 1'b1;
          end
        end
        ST_DONE: begin
          if (response_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multibyte_adder_sequencer.sv
// tb_multibyte_adder_sequencer
// Directed vectors with hand-computed results for a WORDS=4 instance and a
// WORDS=1 instance sharing one clock and reset.

module tb_multibyte_adder_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        request_valid = 1'b0;
  logic        request_ready;
  logic [1:0]  operation = 2'b00;
  logic [31:0] source_element_0 = '0;
  logic [31:0] source_element_1 = '0;
  logic        input_carry = 1'b0;
  logic        response_valid;
  logic        response_ready = 1'b0;
  logic [31:0] result;
  logic        output_carry;
  logic        overflow;
  logic        zero;

  logic        w1_request_valid = 1'b0;
  logic        w1_request_ready;
  logic [1:0]  w1_operation = 2'b00;
  logic [7:0]  w1_source_element_0 = '0;
  logic [7:0]  w1_source_element_1 = '0;
  logic        w1_input_carry = 1'b0;
  logic        w1_response_valid;
  logic        w1_response_ready = 1'b0;
  logic [7:0]  w1_result;
  logic        w1_output_carry;
  logic        w1_overflow;
  logic        w1_zero;

  int compare_count  = 0;
  int mismatch_count = 0;

  multibyte_adder_sequencer #(.WORDS(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .request_valid    (request_valid),
    .request_ready    (request_ready),
    .operation        (operation),
    .source_element_0 (source_element_0),
    .source_element_1 (source_element_1),
    .input_carry      (input_carry),
    .response_valid   (response_valid),
    .response_ready   (response_ready),
    .result           (result),
    .output_carry     (output_carry),
    .overflow         (overflow),
    .zero             (zero)
  );

  multibyte_adder_sequencer #(.WORDS(1)) dut_w1 (
    .clock            (clock),
    .reset            (reset),
    .request_valid    (w1_request_valid),
    .request_ready    (w1_request_ready),
    .operation        (w1_operation),
    .source_element_0 (w1_source_element_0),
    .source_element_1 (w1_source_element_1),
    .input_carry      (w1_input_carry),
    .response_valid   (w1_response_valid),
    .response_ready   (w1_response_ready),
    .result           (w1_result),
    .output_carry     (w1_output_carry),
    .overflow         (w1_overflow),
    .zero             (w1_zero)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one operation on the WORDS=4 instance, scramble inputs after acceptance,
  // hold the response for hold_cycles, then complete the handshake.
  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic cin, input int hold_cycles,
                               input logic [31:0] exp_result, input logic exp_carry,
                               input logic exp_overflow, input logic exp_zero);
    int cnt;
    checkOutput({tag, " ready_before"}, request_ready, 1);
    operation        = op;
    source_element_0 = a;
    source_element_1 = b;
    input_carry      = cin;
    request_valid    = 1'b1;
    @(posedge clock); #1;
    request_valid    = 1'b0;
    operation        = ~op;
    source_element_0 = 32'hA5A5_5A5A;
    source_element_1 = 32'h3C3C_C3C3;
    input_carry      = ~cin;
    checkOutput({tag, " ready_in_run"}, request_ready, 0);
    cnt = 0;
    while (!response_valid && cnt < 40) begin
      @(posedge clock); #1;
      cnt++;
    end
    checkOutput({tag, " latency"}, cnt, 4);
    checkOutput({tag, " result"}, result, exp_result);
    checkOutput({tag, " carry"}, output_carry, exp_carry);
    checkOutput({tag, " overflow"}, overflow, exp_overflow);
    checkOutput({tag, " zero"}, zero, exp_zero);
    for (int i = 0; i < hold_cycles; i++) begin
      @(posedge clock); #1;
      checkOutput({tag, " hold_valid"}, response_valid, 1);
      checkOutput({tag, " hold_ready"}, request_ready, 0);
      checkOutput({tag, " hold_result"}, result, exp_result);
      checkOutput({tag, " hold_carry"}, output_carry, exp_carry);
    end
    response_ready = 1'b1;
    @(posedge clock); #1;
    response_ready = 1'b0;
    checkOutput({tag, " valid_after"}, response_valid, 0);
    checkOutput({tag, " ready_after"}, request_ready, 1);
    checkOutput({tag, " idle_result"}, result, exp_result);
  endtask

  initial begin
    int cnt;
    int accepts[$];

    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("reset ready", request_ready, 1);
    checkOutput("reset valid", response_valid, 0);
    checkOutput("reset result", result, 0);
    checkOutput("reset carry", output_carry, 0);
    checkOutput("reset overflow", overflow, 0);
    checkOutput("reset zero", zero, 0);

    applyStimulus("add_ff_1",   2'b00, 32'h0000_00FF, 32'h0000_0001, 1'b0, 0, 32'h0000_0100, 0, 0, 0);
    applyStimulus("add_wrap",   2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 32'h0000_0000, 1, 0, 1);
    applyStimulus("add_ovf",    2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 32'h8000_0000, 0, 1, 0);
    applyStimulus("sub_borrow", 2'b01, 32'h0000_0000, 32'h0000_0001, 1'b0, 0, 32'hFFFF_FFFF, 0, 0, 0);
    applyStimulus("sub_ovf",    2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0, 0, 32'h7FFF_FFFF, 1, 1, 0);
    applyStimulus("sub_zero",   2'b01, 32'h0000_0005, 32'h0000_0005, 1'b1, 0, 32'h0000_0000, 1, 0, 1);
    applyStimulus("sbb",        2'b11, 32'h0000_0005, 32'h0000_0002, 1'b0, 0, 32'h0000_0002, 1, 0, 0);
    applyStimulus("adc_hold",   2'b10, 32'h1234_5678, 32'h1111_1111, 1'b1, 3, 32'h2345_678A, 0, 0, 0);

    // Reset in the middle of a RUN discards the operation.
    operation        = 2'b00;
    source_element_0 = 32'h0102_0304;
    source_element_1 = 32'h0101_0101;
    request_valid    = 1'b1;
    @(posedge clock); #1;
    request_valid = 1'b0;
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("midrun ready", request_ready, 1);
    checkOutput("midrun valid", response_valid, 0);
    checkOutput("midrun result", result, 0);
    checkOutput("midrun carry", output_carry, 0);
    checkOutput("midrun overflow", overflow, 0);
    checkOutput("midrun zero", zero, 0);
    reset = 1'b0;
    applyStimulus("after_reset", 2'b00, 32'h0000_0001, 32'h0000_0001, 1'b0, 0, 32'h0000_0002, 0, 0, 0);

    // Single-byte instance: one RUN cycle.
    checkOutput("w1 ready", w1_request_ready, 1);
    w1_operation        = 2'b00;
    w1_source_element_0 = 8'h80;
    w1_source_element_1 = 8'h80;
    w1_request_valid    = 1'b1;
    @(posedge clock); #1;
    w1_request_valid = 1'b0;
    cnt = 0;
    while (!w1_response_valid && cnt < 40) begin
      @(posedge clock); #1;
      cnt++;
    end
    checkOutput("w1 latency", cnt, 1);
    checkOutput("w1 result", w1_result, 8'h00);
    checkOutput("w1 carry", w1_output_carry, 1);
    checkOutput("w1 overflow", w1_overflow, 1);
    checkOutput("w1 zero", w1_zero, 1);
    w1_response_ready = 1'b1;
    @(posedge clock); #1;
    w1_response_ready = 1'b0;
    checkOutput("w1 valid_after", w1_response_valid, 0);

    // Back-to-back requests with the consumer always ready.
    w1_source_element_0 = 8'h10;
    w1_source_element_1 = 8'h01;
    w1_request_valid    = 1'b1;
    w1_response_ready   = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (w1_request_ready) accepts.push_back(c);
      @(posedge clock); #1;
    end
    w1_request_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    w1_response_ready = 1'b0;
    checkOutput("w1 accept_count", accepts.size(), 4);
    for (int i = 1; i < accepts.size(); i++) begin
      checkOutput("w1 accept_spacing", accepts[i] - accepts[i-1], 3);
    end
    checkOutput("w1 b2b_result", w1_result, 8'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule

// File: doc/multibyte_adder_sequencer.md
Name: multibyte_adder_sequencer

Overview:
- Sequences one shared 8-bit adder slice (carry_8 Kogge-Stone network plus sum XOR) across WORDS bytes to perform wide add/subtract, one byte per cycle, least-significant byte first.
- Chains the slice's output_carry into the next byte's input_carry through a register.
- Valid/ready request and response handshakes; sits between the ALU issue logic and the wide-operand register file.

Parameters:
- WORDS, 4, number of 8-bit bytes per operand; legal range 1..16; operand width is 8*WORDS.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- request_valid  input  1  request presented
- request_ready  output  1  block can accept a request
- operation  input  2  00 ADD, 01 SUB, 10 ADC (add with input_carry), 11 SBB (subtract with borrow = ~input_carry)
- source_element_0  input  8*WORDS  operand A
- source_element_1  input  8*WORDS  operand B
- input_carry  input  1  carry/borrow-in, used only by ADC/SBB
- response_valid  output  1  result valid
- response_ready  input  1  consumer accepts result
- result  output  8*WORDS  A+B(+c) or A-B(-b), modulo 2^(8*WORDS)
- output_carry  output  1  carry out of MSB; for SUB/SBB 1 = no borrow
- overflow  output  1  signed overflow
- zero  output  1  result == 0

Behaviour:
- Single clock domain (clock); reset is synchronous, active-high.
- Reset values: request_ready=1, response_valid=0, result=0, output_carry=0, overflow=0, zero=0; FSM=IDLE; byte index=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - request_ready=1.
  - On request_valid & request_ready, capture A, B and operation.
  - Compute the initial carry: ADD=0, SUB=1, ADC=input_carry, SBB=input_carry.
  - Clear the result register and go to RUN with index=0.
- RUN:
  - request_ready=0. Each cycle, feed byte[index] of A and byte[index] of B (B bitwise inverted for SUB/SBB) plus the registered carry into the slice.
  - sum bit j = (a_j ^ b_j) ^ bitwise_carry[j].
  - Write the sum to result byte[index], register the slice's output_carry as the next carry, and increment index.
  - When index == WORDS-1:
    - Latch output_carry.
    - Latch overflow = bitwise_carry[7] ^ slice output_carry (carry into MSB XOR carry out).
    - Latch zero = (all result bytes, including the current byte, == 0).
    - Go to DONE.
- DONE:
  - response_valid=1; result, output_carry, overflow and zero are held stable.
  - On response_ready, go to IDLE. response_valid drops and request_ready rises on the next cycle.
  - No request is accepted in the same cycle as the response handshake.
- Latency: for acceptance at edge k, response_valid is first high after edge k+WORDS. Throughput is one operation per WORDS+2 cycles when response_ready is held high.
- WORDS=1: RUN lasts exactly one cycle; the first-byte and last-byte conditions coincide.
- Operand/input changes after acceptance are ignored, since captured copies are used.
- request_valid while not ready: no effect; the requester must hold the request.
- response_ready while response_valid=0: ignored.
- Outputs keep their values from the previous operation while in IDLE; they are only overwritten during RUN.
- Reset asserted in any state, including mid-RUN: on the next edge return to reset values; the partial result is discarded and no response is produced.
- Arithmetic wraps modulo 2^(8*WORDS). No saturation.

Test Plan:
- WORDS=4, ADD A=0x000000FF, B=0x00000001, accept at edge k -> response_valid after edge k+4; result=0x00000100, output_carry=0, overflow=0, zero=0.
- ADD A=0xFFFFFFFF, B=0x00000001 -> result=0x00000000, output_carry=1, overflow=0, zero=1. ADD A=0x7FFFFFFF, B=0x00000001 -> result=0x80000000, overflow=1, output_carry=0.
- SUB A=0x00000000, B=0x00000001 -> result=0xFFFFFFFF, output_carry=0 (borrow), overflow=0. SBB A=0x00000005, B=0x00000002, input_carry=0 -> result=0x00000002, output_carry=1.
- ADC A=0x12345678, B=0x11111111, input_carry=1 -> result=0x2345678A. Hold response_ready=0 for 3 cycles -> response_valid and outputs stable, request_ready=0 throughout. Change source_element_* during RUN -> result unchanged.
- Assert reset after edge k+2 of a RUN -> next cycle request_ready=1, response_valid=0, all outputs 0. A new ADD 0x00000001+0x00000001 then returns 0x00000002.
- WORDS=1 build: ADD 0x80+0x80 -> response_valid after edge k+1; result=0x00, output_carry=1, overflow=1, zero=1. Back-to-back requests with response_ready=1 -> accept spacing of exactly 3 cycles.
